// File: rtl/key_event_pkg.sv
// key_event_pkg: shared constants for the key gesture decoder.
//   - state_e: one-hot FSM encoding (5 bits).
//   - TimerW: width of the millisecond timer.
//   - Default values for the key_event timing parameters.
package key_event_pkg;

    typedef enum logic [4:0] {
        StIdle   = 5'b00001,
        StPress1 = 5'b00010,
        StWait2  = 5'b00100,
        StPress2 = 5'b01000,
        StHold   = 5'b10000
    } state_e;

    localparam int unsigned TimerW = 16;

    localparam int unsigned TickDivDefault  = 50_000;
    localparam int unsigned LongMsDefault   = 1000;
    localparam int unsigned DclickMsDefault = 300;
    localparam int unsigned RepeatMsDefault = 100;

endpackage

// File: rtl/ms_tick.sv
// ms_tick: millisecond prescaler.
// Counts 0..TICK_DIV-1 and raises tick_o for the one cycle the counter sits at
// its terminal count. clr_i restarts the count from 0 on the next edge.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   clr_i   in   synchronous clear of the count
//   tick_o  out  one-cycle tick at terminal count
module ms_tick #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event.sv
// key_event: key gesture decoder placed after the key debouncer.
// Classifies gestures into short press, double click and long press, and
// emits registered one-cycle pulses. Optional auto-repeat while a long press
// is held is compiled in when KEY_EVENT_REPEAT_EN is defined; otherwise
// key_repeat is tied to 0.
// Ports:
//   clk_50mhz     in   system clock
//   rst           in   synchronous active-high reset
//   key_flag      in   one-cycle debounced edge strobe
//   key_state     in   debounced level, 0 = pressed
//   short_press   out  one-cycle pulse
//   double_click  out  one-cycle pulse
//   long_press    out  one-cycle pulse
//   key_repeat    out  one-cycle pulse (0 unless KEY_EVENT_REPEAT_EN)
//   key_held      out  high while in HOLD
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TickDivDefault,
    parameter int unsigned LONG_MS   = LongMsDefault,
    parameter int unsigned DCLICK_MS = DclickMsDefault,
    parameter int unsigned REPEAT_MS = RepeatMsDefault
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic key_repeat,
    output logic key_held
);

    localparam logic [TimerW-1:0] LongLim   = TimerW'(LONG_MS);
    localparam logic [TimerW-1:0] DclickLim = TimerW'(DCLICK_MS);

    state_e state_q, state_d;

    logic [TimerW-1:0] timer_q, timer_d, timer_inc;
    logic tick;
    logic clr;
    logic press, release_ev;
    logic long_hit, dclick_hit, rep_hit;

    logic short_press_q, short_press_d;
    logic double_click_q, double_click_d;
    logic long_press_q, long_press_d;
    logic key_held_q, key_held_d;

    assign press      = key_flag && !key_state;
    assign release_ev = key_flag && key_state;

    ms_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_ms_tick (
        .clk_i (clk_50mhz),
        .rst_i (rst),
        .clr_i (clr),
        .tick_o(tick)
    );

    // Saturating increment; a timeout fires on the tick that makes the timer
    // reach its limit so the event lands exactly limit*TICK_DIV cycles later.
    assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + TimerW'(1);
    assign long_hit   = tick && (timer_inc >= LongLim);
    assign dclick_hit = tick && (timer_inc >= DclickLim);

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [TimerW-1:0] RepeatLim = TimerW'(REPEAT_MS);
    logic key_repeat_q, key_repeat_d;

    assign rep_hit = (state_q == StHold) && tick && (timer_inc >= RepeatLim);
`else
    logic unused_repeat_ms;
    assign unused_repeat_ms = ^REPEAT_MS;
    assign rep_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Key events are tested before timeouts so they win a tie.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (press) state_d = StPress1;
            end
            StPress1: begin
                if (release_ev)    state_d = StWait2;
                else if (long_hit) state_d = StHold;
            end
            StWait2: begin
                if (press)           state_d = StPress2;
                else if (dclick_hit) state_d = StIdle;
            end
            StPress2: begin
                if (release_ev) state_d = StIdle;
            end
            StHold: begin
                if (release_ev) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Every transition restarts prescaler and timer so timing is exact.
    assign clr = (state_d != state_q);

    always_comb begin
        timer_d = timer_q;
        if (clr || rep_hit) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = timer_inc;
        end
    end

    // Outputs, decoded from the transition being taken.
    always_comb begin
        short_press_d  = (state_q == StWait2) && (state_d == StIdle);
        double_click_d = (state_q == StWait2) && (state_d == StPress2);
        long_press_d   = (state_q == StPress1) && (state_d == StHold);
        key_held_d     = (state_d == StHold);
`ifdef KEY_EVENT_REPEAT_EN
        key_repeat_d   = rep_hit && (state_d == StHold);
`endif
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            timer_q        <= '0;
            short_press_q  <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            key_held_q     <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            short_press_q  <= short_press_d;
            double_click_q <= double_click_d;
            long_press_q   <= long_press_d;
            key_held_q     <= key_held_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            key_repeat_q <= 1'b0;
        end else begin
            key_repeat_q <= key_repeat_d;
        end
    end

    assign key_repeat = key_repeat_q;
`else
    assign key_repeat = 1'b0;
`endif

    assign short_press  = short_press_q;
    assign double_click = double_click_q;
    assign long_press   = long_press_q;
    assign key_held     = key_held_q;

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

    localparam int unsigned TD = 10;
    localparam int unsigned LM = 5;
    localparam int unsigned DM = 3;
    localparam int unsigned RM = 2;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit RepOn = 1'b1;
`else
    localparam bit RepOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic short_press, double_click, long_press, key_repeat, key_held;

    always #5 clk = ~clk;

    key_event #(
        .TICK_DIV (TD),
        .LONG_MS  (LM),
        .DCLICK_MS(DM),
        .REPEAT_MS(RM)
    ) dut (
        .clk_50mhz   (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .key_repeat  (key_repeat),
        .key_held    (key_held)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Times are cycle indices: event at t means key_flag high in cycle t,
    // first pulse time is the cycle in which the output is seen high.
    typedef struct {
        string name;
        int pa, ra, pb, rb;
        int e_short, e_dclick, e_long, e_rep, e_rep_n, e_hrise, e_hfall;
    } vec_t;

    vec_t vecs[8];

    int f_short, n_short, f_dclick, n_dclick, f_long, n_long, f_rep, n_rep;
    int f_hrise, f_hfall, n_multi;

    task automatic clear_rec();
        f_short = -1; n_short = 0; f_dclick = -1; n_dclick = 0;
        f_long = -1;  n_long = 0;  f_rep = -1;    n_rep = 0;
        f_hrise = -1; f_hfall = -1; n_multi = 0;
    endtask

    task automatic sample(input int t);
        if (short_press === 1'b1) begin
            if (f_short < 0) f_short = t;
            n_short++;
        end
        if (double_click === 1'b1) begin
            if (f_dclick < 0) f_dclick = t;
            n_dclick++;
        end
        if (long_press === 1'b1) begin
            if (f_long < 0) f_long = t;
            n_long++;
        end
        if (key_repeat === 1'b1) begin
            if (f_rep < 0) f_rep = t;
            n_rep++;
        end
        if (key_held === 1'b1 && f_hrise < 0) f_hrise = t;
        if (key_held === 1'b0 && f_hrise >= 0 && f_hfall < 0) f_hfall = t;
        if (int'(short_press) + int'(double_click) + int'(long_press) + int'(key_repeat) > 1)
            n_multi++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_flag = 1'b0;
        key_state = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input int t, input int pa, input int ra, input int pb, input int rb);
        if (t == pa || t == pb) begin
            key_flag = 1'b1;
            key_state = 1'b0;
        end else if (t == ra || t == rb) begin
            key_flag = 1'b1;
            key_state = 1'b1;
        end else begin
            key_flag = 1'b0;
            key_state = 1'($urandom & 1);
        end
    endtask

    function automatic int cnt(input int first);
        return (first >= 0) ? 1 : 0;
    endfunction

    initial begin
        vecs[0] = '{"short",      0,  20, -1,  -1,  51, -1, -1, -1, 0, -1, -1};
        vecs[1] = '{"double",     0,  20, 35,  50,  -1, 36, -1, -1, 0, -1, -1};
        vecs[2] = '{"long",       0, 120, -1,  -1,  -1, -1, 51,
                    RepOn ? 71 : -1, RepOn ? 3 : 0, 51, 121};
        vecs[3] = '{"collide",    0,  50, -1,  -1,  81, -1, -1, -1, 0, -1, -1};
        vecs[4] = '{"early_rel",  0,  49, -1,  -1,  80, -1, -1, -1, 0, -1, -1};
        vecs[5] = '{"late_rel",   0,  51, -1,  -1,  -1, -1, 51, -1, 0, 51, 52};
        vecs[6] = '{"dc_collide", 0,  10, 40, 120,  -1, 41, -1, -1, 0, -1, -1};
        vecs[7] = '{"ignored",   10,   5, -1,  30,  61, -1, -1, -1, 0, -1, -1};

        // Reset state.
        do_reset();
        check("rst_short", int'(short_press), 0);
        check("rst_dclick", int'(double_click), 0);
        check("rst_long", int'(long_press), 0);
        check("rst_repeat", int'(key_repeat), 0);
        check("rst_held", int'(key_held), 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            clear_rec();
            for (int t = 0; t < 170; t++) begin
                drive(t, vecs[v].pa, vecs[v].ra, vecs[v].pb, vecs[v].rb);
                step();
                sample(t + 1);
            end
            key_flag = 1'b0;
            check({vecs[v].name, "_short_t"}, f_short, vecs[v].e_short);
            check({vecs[v].name, "_short_n"}, n_short, cnt(vecs[v].e_short));
            check({vecs[v].name, "_dclick_t"}, f_dclick, vecs[v].e_dclick);
            check({vecs[v].name, "_dclick_n"}, n_dclick, cnt(vecs[v].e_dclick));
            check({vecs[v].name, "_long_t"}, f_long, vecs[v].e_long);
            check({vecs[v].name, "_long_n"}, n_long, cnt(vecs[v].e_long));
            check({vecs[v].name, "_rep_t"}, f_rep, vecs[v].e_rep);
            check({vecs[v].name, "_rep_n"}, n_rep, vecs[v].e_rep_n);
            check({vecs[v].name, "_held_rise"}, f_hrise, vecs[v].e_hrise);
            check({vecs[v].name, "_held_fall"}, f_hfall, vecs[v].e_hfall);
            check({vecs[v].name, "_onehot"}, n_multi, 0);
        end

        // Repeat spacing: pulses every RM*TD cycles after the first one.
        do_reset();
        clear_rec();
        begin
            int last_rep;
            int bad_gap;
            last_rep = -1;
            bad_gap = 0;
            for (int t = 0; t < 160; t++) begin
                drive(t, 0, 150, -1, -1);
                step();
                if (key_repeat === 1'b1) begin
                    if (last_rep >= 0 && (t + 1 - last_rep) != int'(RM * TD)) bad_gap++;
                    last_rep = t + 1;
                end
                sample(t + 1);
            end
            check("rep_gap", bad_gap, 0);
            check("rep_count", n_rep, RepOn ? 4 : 0);
        end

        // Reset mid-gesture in WAIT2, then a fresh gesture.
        do_reset();
        clear_rec();
        for (int t = 0; t < 140; t++) begin
            drive(t, 0, 20, 60, 70);
            rst = (t == 30);
            step();
            if (t == 30) begin
                check("midrst_short", int'(short_press), 0);
                check("midrst_dclick", int'(double_click), 0);
                check("midrst_long", int'(long_press), 0);
                check("midrst_held", int'(key_held), 0);
            end
            sample(t + 1);
        end
        rst = 1'b0;
        key_flag = 1'b0;
        check("midrst_short_t", f_short, 101);
        check("midrst_short_n", n_short, 1);
        check("midrst_dclick_n", n_dclick, 0);
        check("midrst_long_n", n_long, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Key gesture decoder directly downstream of the key debouncer.
- Consumes the debouncer's one-cycle `key_flag` and its level `key_state`.
- Classifies each gesture as short press, double click or long press, and emits one-cycle event pulses to application logic, such as the UART send trigger.
- Optionally generates auto-repeat pulses while a long press is held.

## Interface
Parameters:
- `TICK_DIV`, 50_000: clock cycles per 1 ms timebase tick (50 MHz clock).
- `LONG_MS`, 1000: hold time in ms that qualifies a long press.
- `DCLICK_MS`, 300: window in ms after the first release in which a second press makes a double click.
- `REPEAT_MS`, 100: auto-repeat period in ms (used only with `KEY_REPEAT_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk_50mhz`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `key_flag`  in  1  one-cycle debounced edge strobe.
- `key_state`  in  1  debounced level, 0 = pressed.
- `short_press`  out  1  one-cycle pulse, registered.
- `double_click`  out  1  one-cycle pulse, registered.
- `long_press`  out  1  one-cycle pulse, registered.
- `key_repeat`  out  1  one-cycle pulse, registered; constant 0 without `KEY_REPEAT_EN`.
- `key_held`  out  1  level, high while in HOLD.

## Operation
Input decode:
- press = `key_flag && !key_state`
- release = `key_flag && key_state`
- `key_state` is ignored when `key_flag` is 0.

State machine (one-hot): IDLE, PRESS1, WAIT2, PRESS2, HOLD.
- IDLE: on press → PRESS1.
- PRESS1:
  - release → WAIT2.
  - ms timer reaches `LONG_MS` → HOLD, pulse `long_press`.
- WAIT2:
  - press → PRESS2, pulse `double_click`.
  - ms timer reaches `DCLICK_MS` → IDLE, pulse `short_press`.
- PRESS2:
  - release → IDLE.
  - No long-press detection in this state.
- HOLD:
  - release → IDLE.
  - With `KEY_REPEAT_EN`: `key_repeat` pulses every `REPEAT_MS` ms.
- Illegal state → IDLE with no output.

Timebase and timer:
- The prescaler counts 0..`TICK_DIV`-1 and produces a one-cycle ms tick at the terminal count.
- The ms timer is 16 bits and saturates at its maximum value.
- On every state transition, both the prescaler and the ms timer clear to 0, so timing is exact and not tick-aligned.
- In HOLD, the ms timer clears again after each repeat pulse.

Boundary conditions:
- Simultaneous key event and timeout in the same cycle: the key event wins. A release in PRESS1 goes to WAIT2 with no `long_press`; a press in WAIT2 yields `double_click`.
- Reset mid-gesture: the block returns to IDLE with all outputs 0, and no pending event is emitted.
- A press or release that arrives in a state which does not expect it (e.g. release in IDLE) is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, prescaler and timer 0.
- Latency reference: the "event cycle" is the cycle in which `key_flag` is sampled high.
- Pulses (all outputs are registered):
  - `double_click`: high in event cycle + 1.
  - `long_press`: high exactly `LONG_MS`*`TICK_DIV` + 1 cycles after the press event cycle.
  - `short_press`: high `DCLICK_MS`*`TICK_DIV` + 1 cycles after the release event cycle.
  - `key_repeat`: the first pulse comes `REPEAT_MS`*`TICK_DIV` cycles after `long_press`; later pulses come at the same period.
- `key_held`: rises together with `long_press` and falls in release event cycle + 1.
- At most one of the event outputs is high in any cycle.

## Configuration
- Macro `KEY_EVENT_REPEAT_EN`, referred to elsewhere in this document as `KEY_REPEAT_EN`.
- Defined: HOLD generates periodic `key_repeat` pulses as described above.
- Undefined:
  - The repeat logic is not compiled, and `key_repeat` is tied to 0.
  - HOLD only waits for release.
  - All other behaviour is identical.

## Structure
- Package `key_event_pkg` contains:
  - the one-hot state encoding constants, 5 bits;
  - the timer width constant, 16;
  - the default values for `TICK_DIV`, `LONG_MS`, `DCLICK_MS` and `REPEAT_MS`.
- Sub-module `ms_tick`: the prescaler, with a synchronous clear input and a tick output, parameterised by `TICK_DIV`.
- The FSM, ms timer and output registers live in `key_event`.

## Test plan
All scenarios run with `TICK_DIV`=10, `LONG_MS`=5, `DCLICK_MS`=3, `REPEAT_MS`=2.
- Short press: press, then release 20 cycles later → single `short_press` pulse 31 cycles after the release event; no other pulses.
- Double click: press, release after 20 cycles, press again 15 cycles later → `double_click` one cycle after the second press; no `short_press`; second release returns to IDLE.
- Long press with repeat (macro defined): press held for 120 cycles → `long_press` at press event cycle + 51 and `key_held`=1, then `key_repeat` every 20 cycles; release → `key_held`=0 next cycle.
- Long press without the macro: same stimulus → `key_repeat` never asserts.
- Collision: in PRESS1, release exactly in the cycle the timer reaches 5 ms → no `long_press`; `short_press` follows 31 cycles later.
- Reset mid-gesture: assert `rst` during WAIT2 for 1 cycle → no `short_press`; all outputs 0; the next press starts a fresh gesture.
